// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU pipeline: datapath widths and the
// writeback-stage run/halt state encoding.
package cpu_pkg;

    localparam int DW = 16;
    localparam int RW = 4;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } wb_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc unless frozen, sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             freeze,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] q_r;

    // Count register; holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= '0;
        end else if (inc && !freeze && (q_r != {CNT_W{1'b1}})) begin
            q_r <= q_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign q = q_r;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage: captures the completed memory-stage
// instruction, drives register-file write / forwarding, tracks halt and perf counters.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int DW           = cpu_pkg::DW,
    parameter int RW           = cpu_pkg::RW,
    parameter int CNT_W        = 16,
    parameter int R0_HARDWIRED = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dmem_stall,
    input  logic             flush,
    input  logic             valid_in,
    input  logic [DW-1:0]    alu_out,
    input  logic [DW-1:0]    mem_out,
    input  logic             mem_read,
    input  logic             reg_write,
    input  logic [RW-1:0]    dst_in,
    input  logic             halt_in,
    output logic             wb_en,
    output logic [RW-1:0]    wb_dst,
    output logic [DW-1:0]    wb_data,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] stall_cycles
);

    wb_state_e      state_r;
    wb_state_e      state_nxt_s;
    logic           v_r;
    logic           rw_r;
    logic           hlt_r;
    logic [RW-1:0]  dst_r;
    logic [DW-1:0]  data_r;
    logic           halted_s;
    logic           wb_en_s;
    logic           cnt_freeze_s;

    // A registered HALT gates writeback and capture in the same cycle it is seen,
    // so the halt instruction never writes the register file.
    assign halted_s     = (state_r == ST_HALTED) || (v_r && hlt_r);
    assign cnt_freeze_s = (state_r == ST_HALTED);

    // Pipeline register; payload only loads for real instructions to keep X out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r    <= 1'b0;
            rw_r   <= 1'b0;
            hlt_r  <= 1'b0;
            dst_r  <= '0;
            data_r <= '0;
        end else if (!halted_s) begin
            if (flush) begin
                v_r <= 1'b0;
            end else if (dmem_stall) begin
                v_r <= 1'b0;
            end else begin
                v_r <= valid_in;
                if (valid_in) begin
                    rw_r   <= reg_write;
                    dst_r  <= dst_in;
                    hlt_r  <= halt_in;
                    data_r <= mem_read ? mem_out : alu_out;
                end
            end
        end
    end

    // Run/halt state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: HALTED is only left through reset.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (v_r && hlt_r) begin
                    state_nxt_s = ST_HALTED;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALTED: state_nxt_s = ST_HALTED;
            default:   state_nxt_s = ST_RUN;
        endcase
    end

    // Register-file write enable, with optional hardwired-zero r0.
    always_comb begin
        wb_en_s = v_r && rw_r && !halted_s;
        if ((R0_HARDWIRED != 0) && (dst_r == {RW{1'b0}})) begin
            wb_en_s = 1'b0;
        end else begin
            wb_en_s = wb_en_s;
        end
    end

    assign wb_en   = wb_en_s;
    assign wb_dst  = dst_r;
    assign wb_data = data_r;
    assign halted  = halted_s;

    sat_counter #(.CNT_W(CNT_W)) u_retired_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (v_r),
        .freeze (cnt_freeze_s),
        .q      (retired)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (dmem_stall),
        .freeze (cnt_freeze_s),
        .q      (stall_cycles)
    );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: scoreboard of expected writebacks plus
// counter, halt and saturation scenarios (second instance uses 4-bit counters).
module tb_mem_wb_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dmem_stall, flush, valid_in, mem_read, reg_write, halt_in;
    logic [15:0] alu_out, mem_out;
    logic [3:0]  dst_in;

    logic        wb_en, halted;
    logic [3:0]  wb_dst;
    logic [15:0] wb_data, retired, stall_cycles;

    logic        s_wb_en, s_halted;
    logic [3:0]  s_wb_dst;
    logic [15:0] s_wb_data;
    logic [3:0]  s_retired, s_stall_cycles;

    typedef struct packed {
        logic        en;
        logic [3:0]  dst;
        logic [15:0] data;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    wb_exp_t e;
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk(clk), .rst_n(rst_n), .dmem_stall(dmem_stall), .flush(flush),
        .valid_in(valid_in), .alu_out(alu_out), .mem_out(mem_out),
        .mem_read(mem_read), .reg_write(reg_write), .dst_in(dst_in),
        .halt_in(halt_in), .wb_en(wb_en), .wb_dst(wb_dst), .wb_data(wb_data),
        .halted(halted), .retired(retired), .stall_cycles(stall_cycles)
    );

    mem_wb_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .dmem_stall(dmem_stall), .flush(flush),
        .valid_in(valid_in), .alu_out(alu_out), .mem_out(mem_out),
        .mem_read(mem_read), .reg_write(reg_write), .dst_in(dst_in),
        .halt_in(halt_in), .wb_en(s_wb_en), .wb_dst(s_wb_dst), .wb_data(s_wb_data),
        .halted(s_halted), .retired(s_retired), .stall_cycles(s_stall_cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_in = 1'b0; flush = 1'b0; dmem_stall = 1'b0; mem_read = 1'b0;
        reg_write = 1'b0; halt_in = 1'b0; dst_in = 4'd0;
        alu_out = 16'h0000; mem_out = 16'h0000;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid_in = 1'b0; alu_out = 16'hxxxx; mem_out = 16'hxxxx; dst_in = 4'hx;
        reg_write = 1'bx; mem_read = 1'bx; halt_in = 1'bx;
        #2;
        checks++;
        if (wb_en !== 1'b0 || wb_dst !== 4'd0 || wb_data !== 16'h0000 || halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got en=%b dst=%h data=%h halted=%b expected 0/0/0000/0",
                     wb_en, wb_dst, wb_data, halted);
        end
        checks++;
        if (retired !== 16'd0 || stall_cycles !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters: got retired=%0d stall=%0d expected 0/0", retired, stall_cycles);
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (wb_en !== 1'b0 || wb_dst !== 4'd0 || wb_data !== 16'h0000 || retired !== 16'd0) begin
            failures++;
            $display("FAIL no_x_idle: got en=%b dst=%h data=%h retired=%h expected 0/0/0000/0",
                     wb_en, wb_dst, wb_data, retired);
        end
        idle();
    endtask

    task automatic test_alu();
        do_reset();
        valid_in = 1'b1; reg_write = 1'b1; dst_in = 4'd3; alu_out = 16'h1234;
        mem_out = 16'hDEAD;
        exp_q.push_back('{en: 1'b1, dst: 4'd3, data: 16'h1234});
        tick();
        idle();
        e = exp_q.pop_front();
        checks++;
        if (wb_en !== e.en || wb_dst !== e.dst || wb_data !== e.data) begin
            failures++;
            $display("FAIL alu_wb: got en=%b dst=%0d data=%h expected en=%b dst=%0d data=%h",
                     wb_en, wb_dst, wb_data, e.en, e.dst, e.data);
        end
        tick();
        checks++;
        if (retired !== 16'd1 || wb_en !== 1'b0) begin
            failures++;
            $display("FAIL alu_retired: got retired=%0d en=%b expected 1/0", retired, wb_en);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1; reg_write = 1'b1; dst_in = 4'(8 + i);
            alu_out = 16'hA000 + 16'(i); mem_out = 16'h5000 + 16'(i);
            mem_read = (i % 2) == 1;
            exp_q.push_back('{en: 1'b1, dst: 4'(8 + i),
                              data: ((i % 2) == 1) ? 16'h5000 + 16'(i) : 16'hA000 + 16'(i)});
            tick();
            e = exp_q.pop_front();
            checks++;
            if (wb_en !== e.en || wb_dst !== e.dst || wb_data !== e.data) begin
                failures++;
                $display("FAIL b2b_wb[%0d]: got en=%b dst=%0d data=%h expected en=%b dst=%0d data=%h",
                         i, wb_en, wb_dst, wb_data, e.en, e.dst, e.data);
            end
        end
        idle();
        tick();
        checks++;
        if (retired !== 16'd4) begin
            failures++;
            $display("FAIL b2b_retired: got %0d expected 4", retired);
        end
    endtask

    task automatic test_load();
        do_reset();
        valid_in = 1'b1; reg_write = 1'b1; mem_read = 1'b1; dst_in = 4'd5;
        alu_out = 16'h0040; mem_out = 16'h0BAD; dmem_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{en: 1'b0, dst: 4'd0, data: 16'h0000});
            tick();
            e = exp_q.pop_front();
            checks++;
            if (wb_en !== e.en || wb_dst !== e.dst || wb_data !== e.data) begin
                failures++;
                $display("FAIL load_stall[%0d]: got en=%b dst=%0d data=%h expected en=%b dst=%0d data=%h",
                         i, wb_en, wb_dst, wb_data, e.en, e.dst, e.data);
            end
        end
        dmem_stall = 1'b0; mem_out = 16'hBEEF;
        exp_q.push_back('{en: 1'b1, dst: 4'd5, data: 16'hBEEF});
        tick();
        idle();
        e = exp_q.pop_front();
        checks++;
        if (wb_en !== e.en || wb_dst !== e.dst || wb_data !== e.data) begin
            failures++;
            $display("FAIL load_wb: got en=%b dst=%0d data=%h expected en=%b dst=%0d data=%h",
                     wb_en, wb_dst, wb_data, e.en, e.dst, e.data);
        end
        tick();
        checks++;
        if (retired !== 16'd1 || stall_cycles !== 16'd2) begin
            failures++;
            $display("FAIL load_counters: got retired=%0d stall=%0d expected 1/2", retired, stall_cycles);
        end
    endtask

    task automatic test_flush_stall();
        do_reset();
        valid_in = 1'b1; reg_write = 1'b1; dst_in = 4'd2; alu_out = 16'h7777;
        flush = 1'b1; dmem_stall = 1'b1;
        exp_q.push_back('{en: 1'b0, dst: 4'd0, data: 16'h0000});
        tick();
        idle();
        e = exp_q.pop_front();
        checks++;
        if (wb_en !== e.en || wb_dst !== e.dst || wb_data !== e.data) begin
            failures++;
            $display("FAIL flush_stall_wb: got en=%b dst=%0d data=%h expected en=%b dst=%0d data=%h",
                     wb_en, wb_dst, wb_data, e.en, e.dst, e.data);
        end
        tick();
        checks++;
        if (retired !== 16'd0 || stall_cycles !== 16'd1) begin
            failures++;
            $display("FAIL flush_stall_counters: got retired=%0d stall=%0d expected 0/1",
                     retired, stall_cycles);
        end
    endtask

    task automatic test_r0();
        do_reset();
        valid_in = 1'b1; reg_write = 1'b1; dst_in = 4'd0; alu_out = 16'hC0DE;
        exp_q.push_back('{en: 1'b0, dst: 4'd0, data: 16'hC0DE});
        tick();
        idle();
        e = exp_q.pop_front();
        checks++;
        if (wb_en !== e.en || wb_dst !== e.dst || wb_data !== e.data) begin
            failures++;
            $display("FAIL r0_wb: got en=%b dst=%0d data=%h expected en=%b dst=%0d data=%h",
                     wb_en, wb_dst, wb_data, e.en, e.dst, e.data);
        end
        tick();
        checks++;
        if (retired !== 16'd1) begin
            failures++;
            $display("FAIL r0_retired: got %0d expected 1", retired);
        end
    endtask

    task automatic test_halt();
        do_reset();
        valid_in = 1'b1; reg_write = 1'b1; dst_in = 4'd4; alu_out = 16'h1111;
        tick();
        halt_in = 1'b1; dst_in = 4'd6; alu_out = 16'h2222;
        tick();
        idle();
        checks++;
        if (halted !== 1'b1 || wb_en !== 1'b0) begin
            failures++;
            $display("FAIL halt_entry: got halted=%b en=%b expected 1/0", halted, wb_en);
        end
        tick();
        checks++;
        if (halted !== 1'b1 || retired !== 16'd2) begin
            failures++;
            $display("FAIL halt_retired: got halted=%b retired=%0d expected 1/2", halted, retired);
        end
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1; reg_write = 1'b1; dst_in = 4'd3; alu_out = 16'h5555;
            dmem_stall = 1'b1;
            tick();
            checks++;
            if (halted !== 1'b1 || wb_en !== 1'b0) begin
                failures++;
                $display("FAIL halt_hold[%0d]: got halted=%b en=%b expected 1/0", i, halted, wb_en);
            end
        end
        idle();
        tick();
        checks++;
        if (retired !== 16'd2 || stall_cycles !== 16'd0) begin
            failures++;
            $display("FAIL halt_frozen: got retired=%0d stall=%0d expected 2/0", retired, stall_cycles);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || retired !== 16'd0 || stall_cycles !== 16'd0) begin
            failures++;
            $display("FAIL halt_reset: got halted=%b retired=%0d stall=%0d expected 0/0/0",
                     halted, retired, stall_cycles);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            valid_in = 1'b1; reg_write = 1'b1; dst_in = 4'd1; alu_out = 16'(i);
            tick();
        end
        idle();
        tick();
        checks++;
        if (s_retired !== 4'hF || retired !== 16'd20) begin
            failures++;
            $display("FAIL sat_retired: got narrow=%h wide=%0d expected f/20", s_retired, retired);
        end
        for (int i = 0; i < 18; i++) begin
            dmem_stall = 1'b1;
            tick();
        end
        idle();
        tick();
        checks++;
        if (s_stall_cycles !== 4'hF || stall_cycles !== 16'd18 || s_retired !== 4'hF) begin
            failures++;
            $display("FAIL sat_stall: got narrow=%h wide=%0d narrow_ret=%h expected f/18/f",
                     s_stall_cycles, stall_cycles, s_retired);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_alu();
        test_back_to_back();
        test_load();
        test_flush_stall();
        test_r0();
        test_halt();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
